// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
//   SEG_TABLE : logical (active-high) {a,b,c,d,e,f,g} pattern per hex nibble
//   SEG_OFF   : all segments dark (logical)
//   scan_state_e : per-slot scan phase, one BLANK cycle then SHOW
package display_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Entry 15 is leftmost so SEG_TABLE[nib] picks the nibble's pattern.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/multi_display_driver_if.sv
// Bus between datapath and the display driver.
//   master : drives dados/pontos/carregar/suprimir, observes display pins
//   slave  : the driver side
interface multi_display_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] dados;
  logic [N_DIGITS-1:0]   pontos;
  logic                  carregar;
  logic                  suprimir;
  logic [6:0]            segmentos;
  logic                  ponto;
  logic [N_DIGITS-1:0]   anodos;
  logic                  quadro;

  modport master (
    output dados, pontos, carregar, suprimir,
    input  segmentos, ponto, anodos, quadro
  );

  modport slave (
    input  dados, pontos, carregar, suprimir,
    output segmentos, ponto, anodos, quadro
  );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to logical seven-segment decoder.
//   nib_i : hex digit
//   seg_o : {a,b,c,d,e,f,g}, active-high
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/multi_display_driver.sv
// Time-multiplexed N-digit seven-segment driver.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : dados/pontos/suprimir captured on carregar into a pending
//                  copy; segmentos/ponto/anodos/quadro are registered outputs
// Each slot is one BLANK cycle followed by REFRESH_DIV-1 SHOW cycles. Pending
// data moves to the active copy only on the BLANK of digit 0, so a frame is
// never torn.
module multi_display_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ATIVO_BAIXO = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  multi_display_driver_if.slave bus
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic POL = (ATIVO_BAIXO != 0);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] dados;
    logic [N_DIGITS-1:0]   pontos;
    logic                  sup;
  } frame_t;

  frame_t      pend_q, act_q;
  scan_state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          commit;

  logic [N_DIGITS-1:0][6:0] dec;
  logic [N_DIGITS-1:0]      hi_zero;  // nibbles k..N-1 all zero
  logic                     acc;

  logic [N_DIGITS-1:0] anod_l, anod_q;
  logic [6:0]          seg_l, seg_q;
  logic                pt_l, pt_q, quad_l, quad_q;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    hex7seg u_dec (.nib_i(act_q.dados[4*k +: 4]), .seg_o(dec[k]));
  end

  always_comb begin
    hi_zero = '0;
    acc     = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc        = acc & (act_q.dados[4*k +: 4] == 4'h0);
      hi_zero[k] = acc;
    end
  end

  // Scan FSM: BLANK always advances to SHOW; SHOW counts div up to DIV_LAST.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    case (state_q)
      BLANK: begin
        state_d = SHOW;
        div_d   = DW'(1);
        commit  = (idx_q == '0);
      end
      SHOW: begin
        if (div_q == DIV_LAST) begin
          state_d = BLANK;
          div_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      div_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      // On the commit edge the old pending value moves; a load on the same
      // edge stays pending for the next frame.
      if (bus.carregar) pend_q <= {bus.dados, bus.pontos, bus.suprimir};
      if (commit)       act_q  <= pend_q;
    end
  end

  // Logical outputs for the current cycle; registered with polarity applied.
  always_comb begin
    anod_l = '0;
    seg_l  = SEG_OFF;
    pt_l   = 1'b0;
    quad_l = 1'b0;
    if (state_q == SHOW) begin
      anod_l[idx_q] = 1'b1;
      seg_l  = (act_q.sup && idx_q != '0 && hi_zero[idx_q]) ? SEG_OFF : dec[idx_q];
      pt_l   = act_q.pontos[idx_q];
      quad_l = (idx_q == '0) && (div_q == DW'(1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anod_q <= {N_DIGITS{POL}};
      seg_q  <= {7{POL}};
      pt_q   <= POL;
      quad_q <= 1'b0;
    end else begin
      anod_q <= anod_l ^ {N_DIGITS{POL}};
      seg_q  <= seg_l ^ {7{POL}};
      pt_q   <= pt_l ^ POL;
      quad_q <= quad_l;
    end
  end

  assign bus.anodos    = anod_q;
  assign bus.segmentos = seg_q;
  assign bus.ponto     = pt_q;
  assign bus.quadro    = quad_q;

endmodule

// File: tb/tb_multi_display_driver.sv
// Bench for multi_display_driver: two instances (N=4/DIV=4/active-low and
// N=1/DIV=2/active-high) compared every cycle against a timeline model, plus
// literal checks of specific display patterns.
module tb_multi_display_driver;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multi_display_driver_if #(.N_DIGITS(4)) a_if();
  multi_display_driver_if #(.N_DIGITS(1)) b_if();

  multi_display_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ATIVO_BAIXO(1)) dut_a (
    .clock(clock), .reset(reset), .bus(a_if.slave));
  multi_display_driver #(.N_DIGITS(1), .REFRESH_DIV(2), .ATIVO_BAIXO(0)) dut_b (
    .clock(clock), .reset(reset), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       pt;
    logic       q;
  } exp_t;

  logic [6:0] TBL [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Pin values at the end of scan cycle n (cycle 0 = first after reset).
  function automatic exp_t model_out(int n, int nd, int dv, bit ab,
                                     logic [15:0] d, logic [3:0] p, logic s);
    exp_t e;
    int ph, dg;
    logic [15:0] hi;
    e  = '0;
    ph = n % dv;
    dg = (n / dv) % nd;
    if (ph != 0) begin
      hi   = d >> (4 * dg);
      e.an = 4'(1 << dg);
      e.sg = (s && dg > 0 && hi == 16'h0) ? 7'h00 : TBL[hi[3:0]];
      e.pt = p[dg];
      e.q  = (ph == 1 && dg == 0);
    end
    if (ab) begin
      e.an = ~e.an & 4'((1 << nd) - 1);
      e.sg = ~e.sg;
      e.pt = ~e.pt;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Model state
  int na, nb;
  logic [15:0] pa_d, aa_d;
  logic [3:0]  pa_p, aa_p;
  logic        pa_s, aa_s;
  logic [3:0]  pb_d, ab_d;
  logic        pb_p, ab_p, pb_s, ab_s;
  exp_t ea, eb;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      na = 0; nb = 0;
      pa_d = '0; aa_d = '0; pa_p = '0; aa_p = '0; pa_s = 0; aa_s = 0;
      pb_d = '0; ab_d = '0; pb_p = 0; ab_p = 0; pb_s = 0; ab_s = 0;
      ea = model_out(0, 4, 4, 1, 16'h0, 4'h0, 1'b0);
      eb = model_out(0, 1, 2, 0, 16'h0, 4'h0, 1'b0);
    end else begin
      ea = model_out(na, 4, 4, 1, aa_d, aa_p, aa_s);
      if (na % 4 == 0 && (na / 4) % 4 == 0) begin
        aa_d = pa_d; aa_p = pa_p; aa_s = pa_s;
      end
      if (a_if.carregar) begin
        pa_d = a_if.dados; pa_p = a_if.pontos; pa_s = a_if.suprimir;
      end
      na++;
      eb = model_out(nb, 1, 2, 0, {12'h0, ab_d}, {3'b0, ab_p}, ab_s);
      if (nb % 2 == 0) begin
        ab_d = pb_d; ab_p = pb_p; ab_s = pb_s;
      end
      if (b_if.carregar) begin
        pb_d = b_if.dados; pb_p = b_if.pontos[0]; pb_s = b_if.suprimir;
      end
      nb++;
    end
  end

  initial forever begin
    @(negedge clock);
    chk("a_anodos", 32'(a_if.anodos), 32'(ea.an));
    chk("a_seg", 32'(a_if.segmentos), 32'(ea.sg));
    chk("a_ponto", 32'(a_if.ponto), 32'(ea.pt));
    chk("a_quadro", 32'(a_if.quadro), 32'(ea.q));
    chk("b_anodos", 32'(b_if.anodos), 32'(eb.an[0]));
    chk("b_seg", 32'(b_if.segmentos), 32'(eb.sg));
    chk("b_ponto", 32'(b_if.ponto), 32'(eb.pt));
    chk("b_quadro", 32'(b_if.quadro), 32'(eb.q));
  end

  task automatic step(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_qa(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (a_if.quadro) seen = 1;
    end
    chk({nm, "_quadro_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic load_a(input logic [15:0] d, input logic [3:0] p, input logic s);
    a_if.dados = d; a_if.pontos = p; a_if.suprimir = s; a_if.carregar = 1'b1;
    step(1);
    a_if.carregar = 1'b0;
  endtask

  task automatic pin_a(input string nm, input logic [3:0] an, input logic [6:0] sg, input logic pt);
    chk({nm, "_an"}, 32'(a_if.anodos), 32'(an));
    chk({nm, "_seg"}, 32'(a_if.segmentos), 32'(sg));
    chk({nm, "_pt"}, 32'(a_if.ponto), 32'(pt));
  endtask

  initial begin
    int qc;
    a_if.dados = '0; a_if.pontos = '0; a_if.carregar = 0; a_if.suprimir = 0;
    b_if.dados = '0; b_if.pontos = '0; b_if.carregar = 0; b_if.suprimir = 0;
    #1 reset = 1'b1;
    step(3);
    pin_a("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst_q", 32'(a_if.quadro), 32'd0);
    chk("rst_b_an", 32'(b_if.anodos), 32'd0);
    chk("rst_b_seg", 32'(b_if.segmentos), 32'd0);
    reset = 1'b0;
    step(1); chk("rel1_q", 32'(a_if.quadro), 32'd0);
    step(1); chk("rel2_q", 32'(a_if.quadro), 32'd1);
    chk("rel2_bq", 32'(b_if.quadro), 32'd1);

    // 12AF with a point on digit 2
    wait_qa("w1"); load_a(16'h12AF, 4'b0100, 1'b0); wait_qa("w2");
    pin_a("12af_d0", 4'b1110, 7'b0111000, 1'b1);
    step(3); pin_a("12af_blank", 4'b1111, 7'b1111111, 1'b1);
    step(1); pin_a("12af_d1", 4'b1101, 7'b0001000, 1'b1);
    step(4); pin_a("12af_d2", 4'b1011, 7'b0010010, 1'b0);
    step(4); pin_a("12af_d3", 4'b0111, 7'b1001111, 1'b1);

    // Leading-zero suppression
    wait_qa("w3"); load_a(16'h0050, 4'b0000, 1'b1); wait_qa("w4");
    pin_a("sup50_d0", 4'b1110, 7'b0000001, 1'b1);
    step(4); pin_a("sup50_d1", 4'b1101, 7'b0100100, 1'b1);
    step(4); pin_a("sup50_d2", 4'b1011, 7'b1111111, 1'b1);
    step(4); pin_a("sup50_d3", 4'b0111, 7'b1111111, 1'b1);
    wait_qa("w5"); load_a(16'h0000, 4'b0000, 1'b1); wait_qa("w6");
    pin_a("sup0_d0", 4'b1110, 7'b0000001, 1'b1);
    step(4); pin_a("sup0_d1", 4'b1101, 7'b1111111, 1'b1);

    // Two loads mid-frame: last wins, current frame untouched
    wait_qa("w7");
    load_a(16'h1111, 4'h0, 1'b0);
    step(3);
    load_a(16'h2222, 4'h0, 1'b0);
    step(3); pin_a("dbl_old_d2", 4'b1011, 7'b1111111, 1'b1);
    wait_qa("w8");
    pin_a("dbl_d0", 4'b1110, 7'b0010010, 1'b1);
    step(4); pin_a("dbl_d1", 4'b1101, 7'b0010010, 1'b1);

    // Reset during SHOW of digit 2
    wait_qa("w9");
    step(8);
    #2 reset = 1'b1;
    #1 pin_a("mid_rst", 4'hF, 7'h7F, 1'b1);
    chk("mid_rst_q", 32'(a_if.quadro), 32'd0);
    step(2);
    reset = 1'b0;
    step(1); chk("mrel1_q", 32'(a_if.quadro), 32'd0);
    step(1); chk("mrel2_q", 32'(a_if.quadro), 32'd1);
    pin_a("mrel_d0", 4'b1110, 7'b0000001, 1'b1);
    step(12); pin_a("mrel_d3", 4'b0111, 7'b0000001, 1'b1);

    // Single active-high digit, DIV=2
    b_if.dados = 4'h3; b_if.pontos = 1'b1; b_if.carregar = 1'b1;
    step(1); b_if.carregar = 1'b0;
    step(4);
    qc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (b_if.quadro) begin
        qc++;
        chk("b_show_seg", 32'(b_if.segmentos), 32'(7'b1111001));
        chk("b_show_an", 32'(b_if.anodos), 32'd1);
      end else begin
        chk("b_blank_seg", 32'(b_if.segmentos), 32'd0);
        chk("b_blank_an", 32'(b_if.anodos), 32'd0);
      end
    end
    chk("b_quadro_rate", 32'(qc), 32'd2);

    // Random loads, data skewed toward leading zeros
    for (int i = 0; i < 600; i++) begin
      a_if.dados    = 16'($urandom) >> (4 * $urandom_range(0, 4));
      a_if.pontos   = 4'($urandom);
      a_if.suprimir = 1'($urandom);
      a_if.carregar = ($urandom % 6 == 0);
      b_if.dados    = 4'($urandom);
      b_if.pontos   = 1'($urandom);
      b_if.suprimir = 1'($urandom);
      b_if.carregar = ($urandom % 5 == 0);
      step(1);
    end
    a_if.carregar = 1'b0;
    b_if.carregar = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_display_driver.md
# multi_display_driver

Time-multiplexed driver for N seven-segment digits sharing one segment bus. It latches an N-digit hexadecimal value plus per-digit decimal points and scans the digits at a programmable refresh rate. Each digit slot starts with one anti-ghosting blank cycle, and optional leading-zero suppression is supported. The block sits between datapath registers and the board display pins and replaces per-digit combinational decoders.

## Interface
Parameters:
- N_DIGITS, 4: number of digits, ≥ 1.
- REFRESH_DIV, 50000: clock cycles per digit slot, ≥ 2.
- ATIVO_BAIXO, 1: 1 means segments, point and anodes are active-low; 0 means active-high.

Ports:
- clock, in, 1: single clock. All logic is rising-edge.
- reset, in, 1: asynchronous, active-high.
- dados, in, 4*N_DIGITS: hex nibbles. Digit k is dados[4k+3:4k]; digit 0 is least significant (rightmost).
- pontos, in, N_DIGITS: decimal-point request per digit.
- carregar, in, 1: load strobe. Captures dados, pontos and suprimir into the pending register.
- suprimir, in, 1: leading-zero suppression enable, captured with carregar.
- segmentos, out, 7: {a,b,c,d,e,f,g}, bit 6 = a.
- ponto, out, 1: decimal-point segment.
- anodos, out, N_DIGITS: digit enables. One-hot asserted during SHOW, none during BLANK.
- quadro, out, 1: one-cycle pulse on the first SHOW cycle of digit 0.

## Operation
- Registers:
  - pending: dados, pontos, suprimir.
  - active: same fields.
  - div counter: clog2(REFRESH_DIV) bits.
  - digit index idx: max(1, clog2(N_DIGITS)) bits.
  - state: BLANK or SHOW.
- carregar=1 on a clock edge writes pending. If carregar is asserted again before commit, the last value wins.
- Commit (pending → active) happens only on the BLANK cycle where idx has just wrapped to 0, so a frame is never torn. A carregar on that same edge goes to pending and commits next frame.
- Scan FSM:
  - BLANK lasts 1 cycle: anodos all inactive, segments all off, ponto off. Then SHOW.
  - SHOW lasts REFRESH_DIV−1 cycles: anodos[idx] active, segmentos = decode(active nibble idx), ponto = pontos[idx].
  - Leaving SHOW: idx ← idx+1, wrapping N_DIGITS−1 → 0, then BLANK.
- Decode (logical, active-high; inverted when ATIVO_BAIXO=1):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Suppression, when active.suprimir=1:
  - Digit k > 0 is blanked (segments off) if every nibble k..N_DIGITS−1 is 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its ponto if requested. Its anode is still driven.
- Reset values:
  - state = BLANK, idx = 0, div = 0.
  - pending and active all zero.
  - anodos, segmentos and ponto inactive for the polarity (all 1s when ATIVO_BAIXO=1).
  - quadro = 0.
- Reset mid-frame: outputs go inactive immediately (asynchronous). After release, scanning restarts at BLANK of digit 0. The first frame shows zeros unless a load occurs, with suppression off.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Slot = REFRESH_DIV cycles; frame = N_DIGITS × REFRESH_DIV cycles.
- Load to display: carregar at edge t appears on the first SHOW of digit 0 following the next commit. Worst case ≈ one frame + 1 cycle.
- quadro is high exactly one cycle per frame, coincident with the first SHOW cycle of digit 0.
- First cycle after reset release is BLANK of digit 0. First quadro occurs 1 cycle later.
- N_DIGITS=1: idx is a constant 0, every BLANK is a commit point, and quadro pulses every REFRESH_DIV cycles.

## Structure
- Shared package display_pkg holds:
  - the 16-entry logical segment table (active-high constants);
  - the state enum {BLANK, SHOW};
  - the constant for segments-off.
- One combinational sub-module hex7seg: 4-bit nibble in, 7-bit logical segments out, driven from the package table. Polarity inversion happens in the parent's output register.

## Test plan
- Reset, N=4, DIV=4, ATIVO_BAIXO=1: during and after reset anodos=1111, segmentos=1111111, ponto=1. First quadro arrives 2 cycles after release.
- Load dados=16'h12AF, pontos=4'b0100: in the next frame, digit 0 shows F (0111000), digit 1 shows A (0001000), digit 2 shows 2 (0010010) with ponto=0, digit 3 shows 1 (1001111). Each slot is preceded by one all-off cycle.
- Load 16'h0050 with suprimir=1: digits 3 and 2 are off with anode active, digit 1 shows 5, digit 0 shows 0. Repeat with value 0: only digit 0 lit.
- Two carregar pulses mid-frame (16'h1111, then 16'h2222): the current frame is unchanged, and the next frame shows only 2222.
- Assert reset during SHOW of digit 2: outputs go inactive the same cycle. After release, the scan restarts at digit 0 with zeros displayed.
- ATIVO_BAIXO=0, N=1, DIV=2: quadro pulses every 2 cycles, and segments alternate off (0000000) / decode of the nibble.
